// File: rtl/spi_slv_regfile.sv
// SPI mode-0 slave giving access to six 8-bit registers.
// Each frame carries command/data byte pairs. The command byte holds bit7 = read
// and bits[2:0] = address. All SPI inputs are oversampled in the clk domain.
module spi_slv_regfile #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_VAL     = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso,
  output logic [7:0] slv_reg0,
  output logic [7:0] slv_reg1,
  output logic [7:0] slv_reg2,
  output logic [7:0] slv_reg3,
  output logic [7:0] slv_reg4,
  output logic [7:0] slv_reg5,
  output logic       wr_strobe,
  output logic [2:0] wr_addr
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync, vld_sync;
  logic                   sclk_s, mosi_s, ss_s, vld_s;
  logic                   sclk_p1;
  logic                   sclk_rise, sclk_fall;
  logic                   armed;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_sr, rx_nxt;
  logic [7:0]             tx_sr;
  logic                   cmd_rd;
  logic [2:0]             cmd_addr;
  logic [7:0]             rd_val;
  logic                   byte_done, cmd_done, wr_commit;
  logic [7:0]             regs [6];

  // Stage p0: synchronizer chains. vld_sync marks when the ss_n chain holds real samples
  // rather than reset fill, so a frame already in progress at reset release is not mistaken for a new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      vld_sync  <= '0;
      sclk_p1   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
      sclk_p1   <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign vld_s     = vld_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p1;
  assign sclk_fall = ~sclk_s & sclk_p1;

  // Stage p1: byte assembly and event decode
  assign rx_nxt    = {rx_sr[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE);
  assign cmd_done  = byte_done && (state == CMD) && !ss_s;
  // A write that completes on the same cycle that ss_n rises is still committed.
  assign wr_commit = byte_done && (state == DATA) && !cmd_rd && (cmd_addr < 3'd6);

  // Read source mux; invalid addresses read as zero
  always_comb begin
    rd_val = 8'h00;
    case (rx_nxt[2:0])
      3'd0: rd_val = regs[0];
      3'd1: rd_val = regs[1];
      3'd2: rd_val = regs[2];
      3'd3: rd_val = regs[3];
      3'd4: rd_val = regs[4];
      3'd5: rd_val = regs[5];
      default: rd_val = 8'h00;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; ss_n high always wins over byte completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (armed && !ss_s) state_nxt = CMD;
      CMD: begin
        if (ss_s)           state_nxt = IDLE;
        else if (byte_done) state_nxt = DATA;
      end
      DATA: begin
        if (ss_s)           state_nxt = IDLE;
        else if (byte_done) state_nxt = CMD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p2: shift registers, command latch and register writes
  always_ff @(posedge clk) begin
    if (reset) begin
      armed     <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_sr     <= 8'h00;
      tx_sr     <= 8'h00;
      cmd_rd    <= 1'b0;
      cmd_addr  <= 3'd0;
      wr_strobe <= 1'b0;
      wr_addr   <= 3'd0;
      for (int i = 0; i < 6; i++) regs[i] <= RST_VAL;
    end else begin
      wr_strobe <= 1'b0;
      if (ss_s && vld_s) armed <= 1'b1;

      if (state == IDLE || ss_s) begin
        bit_cnt <= 3'd0;
        rx_sr   <= 8'h00;
      end else if (sclk_rise) begin
        rx_sr   <= rx_nxt;
        bit_cnt <= bit_cnt + 3'd1;
        if (cmd_done) begin
          cmd_rd   <= rx_nxt[7];
          cmd_addr <= rx_nxt[2:0];
          tx_sr    <= rx_nxt[7] ? rd_val : 8'h00;
        end
      end else if (sclk_fall && state == DATA && cmd_rd && bit_cnt != 3'd0) begin
        tx_sr <= {tx_sr[6:0], 1'b0};
      end

      if (wr_commit) begin
        wr_strobe <= 1'b1;
        wr_addr   <= cmd_addr;
        for (int i = 0; i < 6; i++) begin
          if (cmd_addr == 3'(i)) regs[i] <= rx_nxt;
        end
      end
    end
  end

  assign miso     = (state == DATA && cmd_rd) ? tx_sr[7] : 1'b0;
  assign slv_reg0 = regs[0];
  assign slv_reg1 = regs[1];
  assign slv_reg2 = regs[2];
  assign slv_reg3 = regs[3];
  assign slv_reg4 = regs[4];
  assign slv_reg5 = regs[5];

endmodule
